bank_timing_fsm: RTL and testbench
==================================

# bank_timing_fsm

Parametrised per-bank controller, successor of the single-bank state machine: one instance per bank, selected by `BANK_ID`. It accepts read/write requests from the command scheduler and tracks the open row (open-page policy with row-hit/row-miss detection). It enforces tRCD/tRP/tRAS/tWR/tRTP internally with counters rather than relying on an external stall. It presents ACT/RD/WR/PRE to the command arbiter over a req/grant handshake.

## Interface

- `ROW_BITS`, 14: row address width
- `COL_BITS`, 14: column address width (must be ≤ `ROW_BITS`)
- `BA_BITS`, 3: bank address width
- `BANK_ID`, 0: bank number this instance serves
- `T_RCD`, `T_RP`, `T_RAS`, `T_WR`, `T_RTP`; defaults 4, 4, 10, 5, 3: timing in clk cycles, each ≥ 1
- `CNT_W`, 5: timing counter width (must hold the largest T_*)

Ports:

- `clk` in 1: clock; single clock domain
- `rst_n` in 1: asynchronous, active-low reset
- `init_done` in 1: device initialisation finished
- `cmd_valid` in 1 / `cmd_ready` out 1: request handshake
- `cmd_rw` in 1: 1 = read, 0 = write
- `cmd_row` in ROW_BITS, `cmd_col` in COL_BITS, `cmd_ba` in BA_BITS
- `cmd_ap` in 1: auto-precharge after the column access
- `issue_req` out 1 / `issue_grant` in 1: arbiter handshake
- `issue_cmd` out 3: 0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE
- `issue_addr` out ROW_BITS: row for ACT, zero-extended column for RD/WR, 0 for PRE and NOP
- `bank_state` out 4: current state encoding
- `bank_busy` out 1: 0 only in IDLE and STANDBY
- `row_open` out 1, `open_row` out ROW_BITS: open-row tracking
- `ref_req` in 1, `ref_ack` out 1: refresh handshake (see Configuration)

## Operation

- **Request acceptance.** A request is accepted on a cycle with `cmd_valid & cmd_ready & (cmd_ba == BANK_ID)`. Requests for other banks are ignored. `rw`, `row`, `col`, and `ap` are captured into a buffer on acceptance.
- **`cmd_ready`** is 1 only in IDLE or STANDBY, and only while `ref_req` is low (when refresh is enabled).
- **Issue.** A command issues on a cycle with `issue_req & issue_grant`. `issue_req`, `issue_cmd`, and `issue_addr` are held stable until granted. `issue_grant` while `issue_req` is 0 is ignored.

State machine; encodings INIT 0, IDLE 1, ACT_REQ 2, RCD 3, RW_REQ 4, STANDBY 5, PRE_REQ 6, RP 7, AP_WAIT 8.

- **INIT** → IDLE when `init_done` = 1.
- **IDLE** → ACT_REQ on accept.
- **ACT_REQ** (ACT, `cmd_row`) → RCD on grant. The grant loads the RCD counter with T_RCD−1 and the tRAS counter with T_RAS−1, sets `row_open`, and sets `open_row` to the buffered row.
- **RCD** → RW_REQ when the counter is 0.
- **RW_REQ** (RD or WR, buffered column) issues, then:
  - loads the recovery counter: T_RTP−1 for reads, T_WR−1 for writes;
  - goes to AP_WAIT if `ap` = 1, otherwise STANDBY.
- **STANDBY**, on accept:
  - row hit (`cmd_row == open_row`) → RW_REQ;
  - row miss → PRE_REQ.
- **PRE_REQ** asserts `issue_req` only when the tRAS counter and the recovery counter are both 0. Grant → RP with counter T_RP−1 and `row_open` cleared.
- **RP** → ACT_REQ when the counter is 0 and a miss request is pending. Otherwise (refresh precharge) → IDLE.
- **AP_WAIT** waits until the tRAS and recovery counters are 0, then T_RP further cycles, then goes to IDLE with `row_open` cleared. No PRE is issued on the bus.
- **Counters** decrement by 1 per cycle and saturate at 0.

## Timing

- **Reset values:**
  - `bank_state`: INIT
  - `cmd_ready`, `issue_req`, `row_open`, `ref_ack`: 0
  - `issue_cmd`: NOP
  - `issue_addr`, `open_row`: 0
  - `bank_busy`: 1
  - all counters: 0
- **Handshake latency:**
  - Accept at cycle t → ACT `issue_req` high at t+1.
  - ACT grant at t → RD/WR `issue_req` first high at t+T_RCD.
  - PRE grant at t → ACT `issue_req` first high at t+T_RP.
- **Row hit** accepted at t → RD/WR `issue_req` at t+1.
- **PRE after ACT:** PRE `issue_req` never rises earlier than T_RAS cycles after the ACT grant.
- **PRE after column access:** PRE `issue_req` never rises earlier than T_RTP (read) or T_WR (write) cycles after the RD/WR grant.
- **Output timing:** all outputs are registered or decoded from registered state only; there is no combinational path from `issue_grant` to `issue_req`.
- **Mid-operation reset:** asynchronous `rst_n` low forces INIT and discards the open row and the buffered request.

## Configuration

- **`BANK_REF_EN` defined:**
  - `ref_req` high blocks `cmd_ready`.
  - In STANDBY, `ref_req` forces PRE_REQ (tRAS and recovery still enforced) → RP → IDLE.
  - In IDLE, `ref_ack` = `ref_req` (combinational from the registered state), and the bank stays in IDLE while `ref_req` is high.
  - In any other state, `ref_req` is honoured on the next entry to STANDBY or IDLE.
- **`BANK_REF_EN` undefined:** `ref_req` is ignored and `ref_ack` is tied to 0.

## Test plan

- **Cold miss read.** Stimulus: `init_done` = 1, BANK_ID = 2, read row 0x05 col 0x10, grant always 1, ap = 0. Required: ACT addr 0x05, RD addr 0x10 exactly 4 cycles later, then STANDBY, `open_row` = 0x05.
- **Row hit.** Stimulus: from STANDBY, write row 0x05 col 0x20. Required: WR issued 1 cycle after accept, no ACT/PRE.
- **Row miss with tRAS/tWR.** Stimulus: write row 0x05 immediately after ACT, then read row 0x09. Required: PRE no earlier than 10 cycles after ACT and 5 after WR, ACT 0x09 4 cycles after PRE grant.
- **Auto-precharge and foreign bank.** Stimulus: read with ap = 1; `cmd_ba` = 3 sent during STANDBY. Required: no PRE on bus, IDLE reached T_RTP+T_RP cycles after RD (tRAS permitting); the bank-3 request is not accepted.
- **Grant stall.** Stimulus: hold `issue_grant` = 0 for 7 cycles during ACT_REQ. Required: `issue_req`, `issue_cmd`, `issue_addr` remain constant, and RCD starts from the grant cycle.
- **Refresh (BANK_REF_EN) and mid-operation reset.** Stimulus: `ref_req` = 1 in STANDBY; separately, reset in RCD. Required: PRE, then IDLE with `ref_ack` = 1 and `cmd_ready` = 0; reset returns all outputs to their reset values.

Source files
------------

// File: rtl/bank_timing_fsm_if.sv
// Signal bundle between one bank controller and its scheduler/arbiter/refresh logic.
// master = scheduler/arbiter side, slave = bank_timing_fsm.
interface bank_timing_fsm_if #(
  parameter int ROW_BITS = 14,
  parameter int COL_BITS = 14,
  parameter int BA_BITS  = 3
) ();
  logic                init_done;
  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_rw;
  logic [ROW_BITS-1:0] cmd_row;
  logic [COL_BITS-1:0] cmd_col;
  logic [BA_BITS-1:0]  cmd_ba;
  logic                cmd_ap;
  logic                issue_req;
  logic                issue_grant;
  logic [2:0]          issue_cmd;
  logic [ROW_BITS-1:0] issue_addr;
  logic [3:0]          bank_state;
  logic                bank_busy;
  logic                row_open;
  logic [ROW_BITS-1:0] open_row;
  logic                ref_req;
  logic                ref_ack;

  modport master (
    output init_done, cmd_valid, cmd_rw, cmd_row, cmd_col, cmd_ba, cmd_ap,
    output issue_grant, ref_req,
    input  cmd_ready, issue_req, issue_cmd, issue_addr,
    input  bank_state, bank_busy, row_open, open_row, ref_ack
  );

  modport slave (
    input  init_done, cmd_valid, cmd_rw, cmd_row, cmd_col, cmd_ba, cmd_ap,
    input  issue_grant, ref_req,
    output cmd_ready, issue_req, issue_cmd, issue_addr,
    output bank_state, bank_busy, row_open, open_row, ref_ack
  );
endinterface

// File: rtl/bank_timing_fsm.sv
// Per-bank open-page controller: tracks the open row and enforces tRCD/tRP/tRAS/tWR/tRTP.
// Define BANK_REF_EN to enable the refresh handshake (ref_req/ref_ack).
module bank_timing_fsm #(
  parameter int ROW_BITS = 14,
  parameter int COL_BITS = 14,
  parameter int BA_BITS  = 3,
  parameter int BANK_ID  = 0,
  parameter int T_RCD    = 4,
  parameter int T_RP     = 4,
  parameter int T_RAS    = 10,
  parameter int T_WR     = 5,
  parameter int T_RTP    = 3,
  parameter int CNT_W    = 5
) (
  input logic              clk,
  input logic              rst_n,
  bank_timing_fsm_if.slave bus
);

  localparam logic [3:0] ST_INIT    = 4'd0;
  localparam logic [3:0] ST_IDLE    = 4'd1;
  localparam logic [3:0] ST_ACT_REQ = 4'd2;
  localparam logic [3:0] ST_RCD     = 4'd3;
  localparam logic [3:0] ST_RW_REQ  = 4'd4;
  localparam logic [3:0] ST_STANDBY = 4'd5;
  localparam logic [3:0] ST_PRE_REQ = 4'd6;
  localparam logic [3:0] ST_RP      = 4'd7;
  localparam logic [3:0] ST_AP_WAIT = 4'd8;

  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_ACT = 3'd1;
  localparam logic [2:0] CMD_RD  = 3'd2;
  localparam logic [2:0] CMD_WR  = 3'd3;
  localparam logic [2:0] CMD_PRE = 3'd4;

  localparam logic [CNT_W-1:0] RCD_LOAD = CNT_W'(T_RCD - 1);
  localparam logic [CNT_W-1:0] RP_LOAD  = CNT_W'(T_RP - 1);
  localparam logic [CNT_W-1:0] RAS_LOAD = CNT_W'(T_RAS - 1);
  localparam logic [CNT_W-1:0] WR_LOAD  = CNT_W'(T_WR - 1);
  localparam logic [CNT_W-1:0] RTP_LOAD = CNT_W'(T_RTP - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [BA_BITS-1:0] MY_BA  = BA_BITS'(BANK_ID);

  logic [3:0]          state_q, state_d;
  logic                buf_rw_q, buf_rw_d;
  logic [ROW_BITS-1:0] buf_row_q, buf_row_d;
  logic [COL_BITS-1:0] buf_col_q, buf_col_d;
  logic                buf_ap_q, buf_ap_d;
  logic                miss_pend_q, miss_pend_d;
  logic                ap_rp_q, ap_rp_d;
  logic                row_open_q, row_open_d;
  logic [ROW_BITS-1:0] open_row_q, open_row_d;
  logic [CNT_W-1:0]    t_cnt_q, t_cnt_d;
  logic [CNT_W-1:0]    ras_cnt_q, ras_cnt_d;
  logic [CNT_W-1:0]    rec_cnt_q, rec_cnt_d;

  logic                ref_hold;
  logic                cmd_ready_c;
  logic                accept;
  logic                row_hit;
  logic                pre_ok;
  logic                issue_req_c;
  logic                grant;
  logic [2:0]          issue_cmd_c;
  logic [ROW_BITS-1:0] issue_addr_c;
  logic [ROW_BITS-1:0] col_ext;

  function automatic logic [CNT_W-1:0] dec_sat(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - CNT_ONE;
  endfunction

`ifdef BANK_REF_EN
  assign ref_hold    = bus.ref_req;
  assign bus.ref_ack = (state_q == ST_IDLE) & bus.ref_req;
`else
  logic unused_ref_req;
  assign unused_ref_req = bus.ref_req;
  assign ref_hold       = 1'b0;
  assign bus.ref_ack    = 1'b0;
`endif

  assign cmd_ready_c = ((state_q == ST_IDLE) | (state_q == ST_STANDBY)) & ~ref_hold;
  assign accept      = bus.cmd_valid & cmd_ready_c & (bus.cmd_ba == MY_BA);
  assign row_hit     = (bus.cmd_row == open_row_q);
  // Precharge may only be requested once both tRAS and write/read recovery have expired.
  assign pre_ok      = (ras_cnt_q == '0) & (rec_cnt_q == '0);
  assign issue_req_c = (state_q == ST_ACT_REQ) | (state_q == ST_RW_REQ) |
                       ((state_q == ST_PRE_REQ) & pre_ok);
  assign grant       = issue_req_c & bus.issue_grant;

  always_comb begin
    col_ext                 = '0;
    col_ext[COL_BITS-1:0]   = buf_col_q;
  end

  always_comb begin
    state_d     = state_q;
    buf_rw_d    = buf_rw_q;
    buf_row_d   = buf_row_q;
    buf_col_d   = buf_col_q;
    buf_ap_d    = buf_ap_q;
    miss_pend_d = miss_pend_q;
    ap_rp_d     = ap_rp_q;
    row_open_d  = row_open_q;
    open_row_d  = open_row_q;
    t_cnt_d     = dec_sat(t_cnt_q);
    ras_cnt_d   = dec_sat(ras_cnt_q);
    rec_cnt_d   = dec_sat(rec_cnt_q);

    if (accept) begin
      buf_rw_d  = bus.cmd_rw;
      buf_row_d = bus.cmd_row;
      buf_col_d = bus.cmd_col;
      buf_ap_d  = bus.cmd_ap;
    end

    case (state_q)
      ST_INIT: begin
        if (bus.init_done) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (accept) begin
          miss_pend_d = 1'b0;
          state_d     = ST_ACT_REQ;
        end
      end
      ST_ACT_REQ: begin
        if (grant) begin
          t_cnt_d    = RCD_LOAD;
          ras_cnt_d  = RAS_LOAD;
          row_open_d = 1'b1;
          open_row_d = buf_row_q;
          // The column request must rise exactly T_RCD cycles after the grant.
          if (T_RCD == 1) state_d = ST_RW_REQ;
          else            state_d = ST_RCD;
        end
      end
      ST_RCD: begin
        if (t_cnt_q <= CNT_ONE) state_d = ST_RW_REQ;
      end
      ST_RW_REQ: begin
        if (grant) begin
          rec_cnt_d = buf_rw_q ? RTP_LOAD : WR_LOAD;
          ap_rp_d   = 1'b0;
          state_d   = buf_ap_q ? ST_AP_WAIT : ST_STANDBY;
        end
      end
      ST_STANDBY: begin
        if (ref_hold) begin
          miss_pend_d = 1'b0;
          state_d     = ST_PRE_REQ;
        end else if (accept) begin
          if (row_hit) begin
            state_d = ST_RW_REQ;
          end else begin
            miss_pend_d = 1'b1;
            state_d     = ST_PRE_REQ;
          end
        end
      end
      ST_PRE_REQ: begin
        if (grant) begin
          t_cnt_d    = RP_LOAD;
          row_open_d = 1'b0;
          if (T_RP == 1) begin
            miss_pend_d = 1'b0;
            state_d     = miss_pend_q ? ST_ACT_REQ : ST_IDLE;
          end else begin
            state_d = ST_RP;
          end
        end
      end
      ST_RP: begin
        if (t_cnt_q <= CNT_ONE) begin
          miss_pend_d = 1'b0;
          state_d     = miss_pend_q ? ST_ACT_REQ : ST_IDLE;
        end
      end
      ST_AP_WAIT: begin
        // Internal precharge: first wait out tRAS/recovery, then a silent tRP window.
        if (!ap_rp_q) begin
          if (pre_ok) begin
            if (T_RP == 1) begin
              row_open_d = 1'b0;
              state_d    = ST_IDLE;
            end else begin
              ap_rp_d = 1'b1;
              t_cnt_d = RP_LOAD;
            end
          end
        end else if (t_cnt_q <= CNT_ONE) begin
          ap_rp_d    = 1'b0;
          row_open_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      buf_rw_q    <= 1'b0;
      buf_row_q   <= '0;
      buf_col_q   <= '0;
      buf_ap_q    <= 1'b0;
      miss_pend_q <= 1'b0;
      ap_rp_q     <= 1'b0;
      row_open_q  <= 1'b0;
      open_row_q  <= '0;
      t_cnt_q     <= '0;
      ras_cnt_q   <= '0;
      rec_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      buf_rw_q    <= buf_rw_d;
      buf_row_q   <= buf_row_d;
      buf_col_q   <= buf_col_d;
      buf_ap_q    <= buf_ap_d;
      miss_pend_q <= miss_pend_d;
      ap_rp_q     <= ap_rp_d;
      row_open_q  <= row_open_d;
      open_row_q  <= open_row_d;
      t_cnt_q     <= t_cnt_d;
      ras_cnt_q   <= ras_cnt_d;
      rec_cnt_q   <= rec_cnt_d;
    end
  end

  // Command/address are shown only while requesting, so they stay frozen until granted.
  always_comb begin
    issue_cmd_c  = CMD_NOP;
    issue_addr_c = '0;
    if (issue_req_c) begin
      case (state_q)
        ST_ACT_REQ: begin
          issue_cmd_c  = CMD_ACT;
          issue_addr_c = buf_row_q;
        end
        ST_RW_REQ: begin
          issue_cmd_c  = buf_rw_q ? CMD_RD : CMD_WR;
          issue_addr_c = col_ext;
        end
        ST_PRE_REQ: issue_cmd_c = CMD_PRE;
        default: issue_cmd_c = CMD_NOP;
      endcase
    end
  end

  assign bus.cmd_ready  = cmd_ready_c;
  assign bus.issue_req  = issue_req_c;
  assign bus.issue_cmd  = issue_cmd_c;
  assign bus.issue_addr = issue_addr_c;
  assign bus.bank_state = state_q;
  assign bus.bank_busy  = ~((state_q == ST_IDLE) | (state_q == ST_STANDBY));
  assign bus.row_open   = row_open_q;
  assign bus.open_row   = open_row_q;

endmodule

// File: tb/tb_bank_timing_fsm.sv
// Bench for bank_timing_fsm: cycle table, hand-written corner sequences, and a
// randomized run checked against a timestamp/queue model of the bank rules.
module tb_bank_timing_fsm;
  localparam int ROW_BITS = 14;
  localparam int COL_BITS = 14;
  localparam int BA_BITS  = 3;
  localparam int BANK_ID  = 2;
  localparam int T_RCD = 4, T_RP = 4, T_RAS = 10, T_WR = 5, T_RTP = 3;
  localparam int NV = 33;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bank_timing_fsm_if #(.ROW_BITS(ROW_BITS), .COL_BITS(COL_BITS), .BA_BITS(BA_BITS)) bus ();

  bank_timing_fsm #(
    .ROW_BITS(ROW_BITS), .COL_BITS(COL_BITS), .BA_BITS(BA_BITS), .BANK_ID(BANK_ID),
    .T_RCD(T_RCD), .T_RP(T_RP), .T_RAS(T_RAS), .T_WR(T_WR), .T_RTP(T_RTP), .CNT_W(5)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input int v, input int rw, input int row, input int col,
                       input int ap, input int ba, input int g);
    bus.cmd_valid   = 1'(v);
    bus.cmd_rw      = 1'(rw);
    bus.cmd_row     = 14'(row);
    bus.cmd_col     = 14'(col);
    bus.cmd_ap      = 1'(ap);
    bus.cmd_ba      = 3'(ba);
    bus.issue_grant = 1'(g);
  endtask

  typedef struct {
    logic        v;
    logic        rw;
    logic [13:0] row;
    logic [13:0] col;
    logic        ap;
    logic [2:0]  ba;
    logic        g;
    logic [3:0]  st;
    logic        rdy;
    logic        req;
    logic [2:0]  cmd;
    logic [13:0] addr;
    logic        ro;
    logic [13:0] orow;
  } vec_t;

  vec_t tbl[NV];

  task automatic vin(input int i, input int rw, input int row, input int col, input int ap, input int ba);
    tbl[i].v   = 1'b1;
    tbl[i].rw  = 1'(rw);
    tbl[i].row = 14'(row);
    tbl[i].col = 14'(col);
    tbl[i].ap  = 1'(ap);
    tbl[i].ba  = 3'(ba);
  endtask

  task automatic vexp(input int i, input int st, input int rdy, input int req, input int cmd,
                      input int addr, input int ro, input int orow);
    tbl[i].st   = 4'(st);
    tbl[i].rdy  = 1'(rdy);
    tbl[i].req  = 1'(req);
    tbl[i].cmd  = 3'(cmd);
    tbl[i].addr = 14'(addr);
    tbl[i].ro   = 1'(ro);
    tbl[i].orow = 14'(orow);
  endtask

  typedef struct {
    logic [2:0]  cmd;
    logic [13:0] addr;
    logic        ap;
  } mcmd_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  initial begin
    int n;
    int rows[4];
    mcmd_t q[$];
    mcmd_t e;
    int head_ready, t_act, t_rw, rec, close_at;
    bit open_m, ap_closing, exp_req, exp_rdy, acc, gr;
    logic [13:0] open_row_m;
    int v, rw, row, col, ap, ba, g;

    drive(0, 0, 0, 0, 0, 0, 1);
    bus.init_done = 1'b0;
    bus.ref_req   = 1'b0;

    // Cycle table: cold miss read, row hit write, miss with tRAS/tWR, foreign bank, auto-precharge.
    for (int i = 0; i < NV; i++) begin
      tbl[i].v = 1'b0; tbl[i].rw = 1'b0; tbl[i].row = '0; tbl[i].col = '0;
      tbl[i].ap = 1'b0; tbl[i].ba = 3'd2; tbl[i].g = 1'b1;
    end
    vin(0, 1, 'h05, 'h10, 0, 2);
    vin(6, 0, 'h05, 'h20, 0, 2);
    vin(8, 1, 'h09, 'h33, 0, 2);
    for (int i = 21; i <= 23; i++) vin(i, 1, 'h07, 'h55, 0, 3);
    vin(24, 1, 'h09, 'h44, 1, 2);
    vexp(0, 1, 1, 0, 0, 0, 0, 0);
    vexp(1, 2, 0, 1, 1, 'h05, 0, 0);
    for (int i = 2; i <= 4; i++) vexp(i, 3, 0, 0, 0, 0, 1, 'h05);
    vexp(5, 4, 0, 1, 2, 'h10, 1, 'h05);
    vexp(6, 5, 1, 0, 0, 0, 1, 'h05);
    vexp(7, 4, 0, 1, 3, 'h20, 1, 'h05);
    vexp(8, 5, 1, 0, 0, 0, 1, 'h05);
    for (int i = 9; i <= 11; i++) vexp(i, 6, 0, 0, 0, 0, 1, 'h05);
    vexp(12, 6, 0, 1, 4, 0, 1, 'h05);
    for (int i = 13; i <= 15; i++) vexp(i, 7, 0, 0, 0, 0, 0, 0);
    vexp(16, 2, 0, 1, 1, 'h09, 0, 0);
    for (int i = 17; i <= 19; i++) vexp(i, 3, 0, 0, 0, 0, 1, 'h09);
    vexp(20, 4, 0, 1, 2, 'h33, 1, 'h09);
    for (int i = 21; i <= 24; i++) vexp(i, 5, 1, 0, 0, 0, 1, 'h09);
    vexp(25, 4, 0, 1, 2, 'h44, 1, 'h09);
    for (int i = 26; i <= 31; i++) vexp(i, 8, 0, 0, 0, 0, 1, 'h09);
    vexp(32, 1, 1, 0, 0, 0, 0, 0);

    // Reset values
    @(negedge clk);
    check("reset.state", 32'(bus.bank_state), 32'd0);
    check("reset.ready", 32'(bus.cmd_ready), 32'd0);
    check("reset.req", 32'(bus.issue_req), 32'd0);
    check("reset.cmd", 32'(bus.issue_cmd), 32'd0);
    check("reset.addr", 32'(bus.issue_addr), 32'd0);
    check("reset.busy", 32'(bus.bank_busy), 32'd1);
    check("reset.row_open", 32'(bus.row_open), 32'd0);
    check("reset.open_row", 32'(bus.open_row), 32'd0);
    check("reset.ref_ack", 32'(bus.ref_ack), 32'd0);
    rst_n = 1'b1;
    bus.init_done = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      check($sformatf("vec%0d.state", i), 32'(bus.bank_state), 32'(tbl[i].st));
      check($sformatf("vec%0d.ready", i), 32'(bus.cmd_ready), 32'(tbl[i].rdy));
      check($sformatf("vec%0d.req", i), 32'(bus.issue_req), 32'(tbl[i].req));
      check($sformatf("vec%0d.cmd", i), 32'(bus.issue_cmd), 32'(tbl[i].cmd));
      check($sformatf("vec%0d.addr", i), 32'(bus.issue_addr), 32'(tbl[i].addr));
      check($sformatf("vec%0d.row_open", i), 32'(bus.row_open), 32'(tbl[i].ro));
      check($sformatf("vec%0d.busy", i), 32'(bus.bank_busy),
            32'((tbl[i].st != 4'd1) && (tbl[i].st != 4'd5)));
      if (tbl[i].ro) check($sformatf("vec%0d.open_row", i), 32'(bus.open_row), 32'(tbl[i].orow));
      drive(32'(tbl[i].v), 32'(tbl[i].rw), 32'(tbl[i].row), 32'(tbl[i].col),
            32'(tbl[i].ap), 32'(tbl[i].ba), 32'(tbl[i].g));
      @(negedge clk);
    end

    // Grant stall in ACT_REQ: outputs frozen, tRCD counted from the grant.
    drive(1, 1, 'h11, 'h22, 0, 2, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 2, 0);
    for (int k = 0; k < 7; k++) begin
      check($sformatf("stall%0d.req", k), 32'(bus.issue_req), 32'd1);
      check($sformatf("stall%0d.cmd", k), 32'(bus.issue_cmd), 32'd1);
      check($sformatf("stall%0d.addr", k), 32'(bus.issue_addr), 32'h11);
      @(negedge clk);
    end
    bus.issue_grant = 1'b1;
    @(negedge clk);
    n = 1;
    while (!bus.issue_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("stall.rcd_latency", 32'(n), 32'(T_RCD));
    check("stall.rw_cmd", 32'(bus.issue_cmd), 32'd2);
    check("stall.rw_addr", 32'(bus.issue_addr), 32'h22);
    @(negedge clk);
    check("stall.standby", 32'(bus.bank_state), 32'd5);

`ifdef BANK_REF_EN
    bus.ref_req = 1'b1;
    #1;
    check("ref.ready_blocked", 32'(bus.cmd_ready), 32'd0);
    n = 0;
    while (!bus.issue_req && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("ref.pre_req", 32'(bus.issue_req), 32'd1);
    check("ref.pre_cmd", 32'(bus.issue_cmd), 32'd4);
    n = 0;
    while (bus.bank_state != 4'd1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("ref.idle", 32'(bus.bank_state), 32'd1);
    check("ref.ack", 32'(bus.ref_ack), 32'd1);
    check("ref.ready_low", 32'(bus.cmd_ready), 32'd0);
    check("ref.row_closed", 32'(bus.row_open), 32'd0);
    @(negedge clk);
    check("ref.stay_idle", 32'(bus.bank_state), 32'd1);
    bus.ref_req = 1'b0;
    #1;
    check("ref.ack_drop", 32'(bus.ref_ack), 32'd0);
    check("ref.ready_back", 32'(bus.cmd_ready), 32'd1);
`else
    bus.ref_req = 1'b1;
    #1;
    check("noref.ready", 32'(bus.cmd_ready), 32'd1);
    check("noref.ack", 32'(bus.ref_ack), 32'd0);
    @(negedge clk);
    check("noref.standby", 32'(bus.bank_state), 32'd5);
    bus.ref_req = 1'b0;
`endif

    // Reset in the middle of RCD.
    drive(1, 1, 'h30, 'h01, 0, 2, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 2, 1);
    n = 0;
    while (bus.bank_state != 4'd3 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("mid.reach_rcd", 32'(bus.bank_state), 32'd3);
    #2;
    rst_n = 1'b0;
    bus.init_done = 1'b0;
    #1;
    check("mid.state", 32'(bus.bank_state), 32'd0);
    check("mid.ready", 32'(bus.cmd_ready), 32'd0);
    check("mid.req", 32'(bus.issue_req), 32'd0);
    check("mid.cmd", 32'(bus.issue_cmd), 32'd0);
    check("mid.addr", 32'(bus.issue_addr), 32'd0);
    check("mid.busy", 32'(bus.bank_busy), 32'd1);
    check("mid.row_open", 32'(bus.row_open), 32'd0);
    check("mid.open_row", 32'(bus.open_row), 32'd0);
    check("mid.ref_ack", 32'(bus.ref_ack), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid.hold_init", 32'(bus.bank_state), 32'd0);
    bus.init_done = 1'b1;
    @(negedge clk);
    check("mid.idle", 32'(bus.bank_state), 32'd1);

    // Randomized traffic against a timestamp/queue model of the bank rules.
    rows[0] = 'h05; rows[1] = 'h09; rows[2] = 'h12; rows[3] = 'h3FFF;
    q.delete();
    head_ready = 0; t_act = -1000; t_rw = -1000; rec = 0; close_at = 0;
    open_m = 1'b0; ap_closing = 1'b0; open_row_m = '0;
    for (int c = 0; c < 3000; c++) begin
      if (ap_closing && c >= close_at) begin
        ap_closing = 1'b0;
        open_m     = 1'b0;
      end
      exp_req = (q.size() != 0) && (c >= head_ready);
      exp_rdy = (q.size() == 0) && !ap_closing;
      check("rnd.ready", 32'(bus.cmd_ready), 32'(exp_rdy));
      check("rnd.req", 32'(bus.issue_req), 32'(exp_req));
      check("rnd.cmd", 32'(bus.issue_cmd), exp_req ? 32'(q[0].cmd) : 32'd0);
      check("rnd.addr", 32'(bus.issue_addr), exp_req ? 32'(q[0].addr) : 32'd0);
      check("rnd.row_open", 32'(bus.row_open), 32'(open_m));
      check("rnd.busy", 32'(bus.bank_busy), 32'(!exp_rdy));
      if (open_m) check("rnd.open_row", 32'(bus.open_row), 32'(open_row_m));

      v   = ($urandom_range(0, 1) == 0) ? 1 : 0;
      rw  = int'($urandom_range(0, 1));
      row = rows[$urandom_range(0, 3)];
      col = int'($urandom_range(0, 16383));
      ap  = ($urandom_range(0, 3) == 0) ? 1 : 0;
      ba  = ($urandom_range(0, 3) == 0) ? 3 : BANK_ID;
      g   = ($urandom_range(0, 3) != 0) ? 1 : 0;
      drive(v, rw, row, col, ap, ba, g);

      acc = (v != 0) && exp_rdy && (ba == BANK_ID);
      gr  = exp_req && (g != 0);
      if (gr) begin
        e = q.pop_front();
        if (e.cmd == 3'd1) begin
          t_act      = c;
          open_m     = 1'b1;
          open_row_m = e.addr;
          head_ready = c + T_RCD;
        end else if (e.cmd == 3'd4) begin
          open_m     = 1'b0;
          head_ready = c + T_RP;
        end else begin
          t_rw = c;
          rec  = (e.cmd == 3'd2) ? T_RTP : T_WR;
          if (e.ap) begin
            ap_closing = 1'b1;
            close_at   = max3(c + rec, t_act + T_RAS, c + 1) + T_RP;
          end
        end
      end
      if (acc) begin
        e.cmd  = (rw != 0) ? 3'd2 : 3'd3;
        e.addr = 14'(col);
        e.ap   = 1'(ap);
        if (open_m && (14'(row) == open_row_m)) begin
          q.push_back(e);
          head_ready = c + 1;
        end else begin
          if (open_m) q.push_back('{cmd: 3'd4, addr: 14'd0, ap: 1'b0});
          q.push_back('{cmd: 3'd1, addr: 14'(row), ap: 1'b0});
          q.push_back(e);
          head_ready = open_m ? max3(c + 1, t_act + T_RAS, t_rw + rec) : c + 1;
        end
      end
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
